maxpool2x2_stream: RTL and testbench

//  Streaming 2x2 / stride-2 max-pool placed directly downstream of the point-conv unit.

---
 rtl/maxpool2x2_stream.sv | 120 ++++++++++++
 tb/tb_maxpool2x2_stream.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 max-pool over a raster-ordered pixel stream.
// One half-width row of horizontal maxima is buffered between row pairs.
module maxpool2x2_stream #(
  parameter int N     = 16,
  parameter int IMG_W = 24,
  parameter int IMG_H = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         din_vld,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout,
  output logic         dout_vld,
  output logic         dout_end
);

  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int LW = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;
  localparam int LD = (IMG_W >= 2) ? (IMG_W / 2) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  if ((IMG_W < 2) || ((IMG_W % 2) != 0)) begin : g_bad_img_w
    $error("maxpool2x2_stream: IMG_W must be even and >= 2");
  end
  if ((IMG_H < 2) || ((IMG_H % 2) != 0)) begin : g_bad_img_h
    $error("maxpool2x2_stream: IMG_H must be even and >= 2");
  end

  function automatic logic [N-1:0] umax(input logic [N-1:0] a, input logic [N-1:0] b);
    return (a >= b) ? a : b;
  endfunction

  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;
  logic [N-1:0]  hold_r;
  logic [N-1:0]  lbuf_r [LD];
  logic [N-1:0]  dout_r;
  logic          dout_vld_r;
  logic          dout_end_r;

  logic [LW-1:0] lb_idx_s;
  logic [N-1:0]  hmax_s;
  logic [N-1:0]  pool_s;
  logic          col_wrap_s;
  logic          row_wrap_s;
  logic          lb_wr_s;
  logic          emit_s;

  // Window datapath: odd columns close a horizontal pair, odd rows close a window.
  always_comb begin
    lb_idx_s   = LW'(col_r >> 1);
    hmax_s     = umax(hold_r, din);
    pool_s     = umax(lbuf_r[lb_idx_s], hmax_s);
    col_wrap_s = (col_r == COL_LAST);
    row_wrap_s = (row_r == ROW_LAST);
    lb_wr_s    = din_vld & col_r[0] & ~row_r[0];
    emit_s     = din_vld & col_r[0] & row_r[0];
  end

  // Raster position, advancing only on accepted pixels.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_r <= '0;
      row_r <= '0;
    end else if (din_vld) begin
      if (col_wrap_s) begin
        col_r <= '0;
        row_r <= row_wrap_s ? '0 : (row_r + RW'(1));
      end else begin
        col_r <= col_r + CW'(1);
      end
    end else begin
      col_r <= col_r;
      row_r <= row_r;
    end
  end

  // Left pixel of each horizontal pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_r <= '0;
    end else if (din_vld && !col_r[0]) begin
      hold_r <= din;
    end else begin
      hold_r <= hold_r;
    end
  end

  // Horizontal maxima of the upper row; contents need no reset since every entry is written first.
  always_ff @(posedge clk) begin
    if (lb_wr_s && !rst) begin
      lbuf_r[lb_idx_s] <= hmax_s;
    end
  end

  // Registered result, valid pulse and end-of-frame marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_r     <= '0;
      dout_vld_r <= 1'b0;
      dout_end_r <= 1'b0;
    end else begin
      dout_vld_r <= emit_s;
      dout_end_r <= emit_s & col_wrap_s & row_wrap_s;
      if (emit_s) begin
        dout_r <= pool_s;
      end else begin
        dout_r <= dout_r;
      end
    end
  end

  assign dout     = dout_r;
  assign dout_vld = dout_vld_r;
  assign dout_end = dout_end_r;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed bench for maxpool2x2_stream: a 4x4 instance for the small frame cases
// and a 24x24 instance compared against a whole-frame golden max-pool.
module tb_maxpool2x2_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        din_vld_a, din_vld_b;
  logic [15:0] din_a, din_b;
  logic [15:0] dout_a, dout_b;
  logic        dout_vld_a, dout_vld_b;
  logic        dout_end_a, dout_end_b;

  always #5 clk = ~clk;

  maxpool2x2_stream #(.N(16), .IMG_W(4), .IMG_H(4)) dut_a (
    .clk(clk), .rst(rst), .din_vld(din_vld_a), .din(din_a),
    .dout(dout_a), .dout_vld(dout_vld_a), .dout_end(dout_end_a)
  );

  maxpool2x2_stream #(.N(16), .IMG_W(24), .IMG_H(24)) dut_b (
    .clk(clk), .rst(rst), .din_vld(din_vld_b), .din(din_b),
    .dout(dout_b), .dout_vld(dout_vld_b), .dout_end(dout_end_b)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] frm [16];
  logic [15:0] exp4 [4];
  logic [15:0] last_a;
  int          end_a;
  logic [15:0] img [576];
  logic [15:0] gold [144];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic cyc_a(input logic v, input logic [15:0] d);
    din_vld_a = v;
    din_a     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_b(input logic v, input logic [15:0] d);
    din_vld_b = v;
    din_b     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    din_vld_a = 1'b0;
    din_vld_b = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_a = 16'd0;
  endtask

  // Feed frm[] to the 4x4 instance; bottom-right pixels are raster indices 5,7,13,15.
  task automatic run_frame4(input int tnum, input bit gaps);
    int k;
    bit br;
    k = 0;
    for (int p = 0; p < 16; p++) begin
      cyc_a(1'b1, frm[p]);
      br = (p == 5) || (p == 7) || (p == 13) || (p == 15);
      if (br) begin
        last_a = exp4[k];
        k++;
      end
      chk($sformatf("t%0d_vld_p%0d", tnum, p), {31'd0, dout_vld_a}, {31'd0, br});
      chk($sformatf("t%0d_dout_p%0d", tnum, p), {16'd0, dout_a}, {16'd0, last_a});
      chk($sformatf("t%0d_end_p%0d", tnum, p), {31'd0, dout_end_a}, (p == 15) ? 32'd1 : 32'd0);
      if (dout_end_a) end_a++;
      if (gaps) begin
        cyc_a(1'b0, 16'hFFFF);
        chk($sformatf("t%0d_bubble_vld_p%0d", tnum, p), {31'd0, dout_vld_a}, 32'd0);
        chk($sformatf("t%0d_bubble_dout_p%0d", tnum, p), {16'd0, dout_a}, {16'd0, last_a});
      end
    end
  endtask

  task automatic ramp4(input logic [15:0] base);
    for (int p = 0; p < 16; p++) frm[p] = base + 16'(p);
    exp4[0] = base + 16'd5;
    exp4[1] = base + 16'd7;
    exp4[2] = base + 16'd13;
    exp4[3] = base + 16'd15;
  endtask

  // Feed img[] to the 24x24 instance and compare against gold[].
  task automatic run_frame24(input int tnum);
    int k;
    int outs;
    bit br;
    k = 0;
    outs = 0;
    for (int p = 0; p < 576; p++) begin
      cyc_b(1'b1, img[p]);
      br = (((p / 24) % 2) == 1) && (((p % 24) % 2) == 1);
      chk($sformatf("t%0d_vld_p%0d", tnum, p), {31'd0, dout_vld_b}, {31'd0, br});
      if (dout_vld_b) outs++;
      if (br) begin
        chk($sformatf("t%0d_dout_w%0d", tnum, k), {16'd0, dout_b}, {16'd0, gold[k]});
        k++;
      end
      chk($sformatf("t%0d_end_p%0d", tnum, p), {31'd0, dout_end_b}, (p == 575) ? 32'd1 : 32'd0);
      if ((p % 37) == 11) begin
        cyc_b(1'b0, 16'd127);
        chk($sformatf("t%0d_bubble_p%0d", tnum, p), {31'd0, dout_vld_b}, 32'd0);
      end
    end
    chk($sformatf("t%0d_out_count", tnum), outs, 32'd144);
  endtask

  task automatic make_gold();
    int a;
    logic [15:0] m;
    for (int wr = 0; wr < 12; wr++) begin
      for (int wc = 0; wc < 12; wc++) begin
        a = (2 * wr) * 24 + 2 * wc;
        m = img[a];
        if (img[a + 1] > m)  m = img[a + 1];
        if (img[a + 24] > m) m = img[a + 24];
        if (img[a + 25] > m) m = img[a + 25];
        gold[wr * 12 + wc] = m;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    din_vld_a = 1'b0;
    din_vld_b = 1'b0;
    din_a = 16'd0;
    din_b = 16'd0;
    end_a = 0;
    last_a = 16'd0;

    do_reset();
    chk("reset_dout_a", {16'd0, dout_a}, 32'd0);
    chk("reset_vld_a", {31'd0, dout_vld_a}, 32'd0);
    chk("reset_end_a", {31'd0, dout_end_a}, 32'd0);
    chk("reset_dout_b", {16'd0, dout_b}, 32'd0);
    chk("reset_vld_b", {31'd0, dout_vld_b}, 32'd0);

    // 1: ramp frame, pixel every cycle
    ramp4(16'd0);
    run_frame4(1, 1'b0);

    // 2: same frame with a bubble after every pixel
    run_frame4(2, 1'b1);

    // 3: window maxima at top-left and bottom-right corners
    for (int p = 0; p < 16; p++) frm[p] = 16'd0;
    frm[0] = 16'd127;
    frm[7] = 16'd99;
    exp4[0] = 16'd127;
    exp4[1] = 16'd99;
    exp4[2] = 16'd0;
    exp4[3] = 16'd0;
    run_frame4(3, 1'b0);

    // 4: two frames back to back
    end_a = 0;
    ramp4(16'd0);
    run_frame4(4, 1'b0);
    ramp4(16'd16);
    run_frame4(5, 1'b0);
    chk("t4_end_pulses", end_a, 32'd2);

    // 5: partial frame stopped before any window completes, then reset with a pixel offered
    for (int p = 0; p < 5; p++) cyc_a(1'b1, 16'd100 + 16'(p));
    chk("t5_partial_no_vld", {31'd0, dout_vld_a}, 32'd0);
    rst = 1'b1;
    din_vld_a = 1'b1;
    din_a = 16'd120;
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_a = 16'd0;
    chk("t5_rst_dout", {16'd0, dout_a}, 32'd0);
    chk("t5_rst_vld", {31'd0, dout_vld_a}, 32'd0);
    ramp4(16'd0);
    run_frame4(6, 1'b0);

    // 6: all-zero 24x24 frame, then random 0..127 frame
    for (int p = 0; p < 576; p++) img[p] = 16'd0;
    make_gold();
    run_frame24(7);
    chk("t6_zero_dout_hold", {16'd0, dout_b}, 32'd0);
    for (int p = 0; p < 576; p++) img[p] = 16'($urandom_range(0, 127));
    make_gold();
    run_frame24(8);
    chk("t6_final_dout_hold", {16'd0, dout_b}, {16'd0, gold[143]});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
